// File: rtl/hp35_ldr_pkg.sv
// Shared types and constants for the hp35 microcode store loader.
package hp35_ldr_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_VRD,
        ST_VWAIT,
        ST_VCMP,
        ST_SETTLE,
        ST_DONE,
        ST_ERROR
    } ldr_state_e;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_VERIFY = 2'd1;
    localparam logic [1:0] ERR_ABORT  = 2'd2;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);
    localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;
    localparam int unsigned SUM_W          = 16;

endpackage

// File: rtl/hp35_rom_loader_if.sv
// Host byte stream and Caravel LA debug port of the hp35 ROM loader.
interface hp35_rom_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              dbg_req;
    logic              dbg_web;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dbg_din;
    logic              dbg_gnt;
    logic [31:0]       dbg_rdata;
    logic              dbg_rvalid;

    modport master (
        output byte_valid, byte_data, dbg_req, dbg_web, dbg_addr, dbg_din,
        input  byte_ready, dbg_gnt, dbg_rdata, dbg_rvalid
    );

    modport slave (
        input  byte_valid, byte_data, dbg_req, dbg_web, dbg_addr, dbg_din,
        output byte_ready, dbg_gnt, dbg_rdata, dbg_rvalid
    );
endinterface

// File: rtl/hp35_ldr_packer.sv
// Little-endian byte-to-word packer with running 16-bit byte checksum.
module hp35_ldr_packer
    import hp35_ldr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic [WORD_W-1:0] word_next_c,
    output logic              word_full_c,
    output logic [SUM_W-1:0]  checksum_o
);

    logic [LANE_W-1:0] idx_q, idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [SUM_W-1:0]  sum_q, sum_d;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        sum_d  = sum_q;
        if (clear_i) begin
            idx_d = '0;
            sum_d = '0;
        end else if (accept_i) begin
            idx_d                        = idx_q + LANE_W'(1);
            word_d[{idx_q, 3'b000} +: 8] = byte_i;
            sum_d                        = sum_q + SUM_W'(byte_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            word_q <= '0;
            sum_q  <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
            sum_q  <= sum_d;
        end
    end

    // The full word is handed out combinationally so the write strobe can
    // carry it in the cycle right after the last byte lands.
    assign word_full_c = accept_i && !clear_i && (idx_q == LANE_W'(BYTES_PER_WORD - 1));
    assign word_next_c = word_d;
    assign word_o      = word_q;
    assign checksum_o  = sum_q;

endmodule

// File: rtl/hp35_rom_loader.sv
// Loads, verifies and guards the hp35 microcode SRAM; arbitrates SRAM port 0
// between the boot loader and a single-word LA debug requester.
module hp35_rom_loader
    import hp35_ldr_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WORDS       = 256,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic                osc_in,
    input  logic                ldr_rst,
    input  logic                start,
    input  logic                abort,
    hp35_rom_loader_if.slave    host,
    output logic                sram_csb0,
    output logic                sram_web0,
    output logic [3:0]          sram_wmask0,
    output logic [ADDR_W-1:0]   sram_addr0,
    output logic [31:0]         sram_din0,
    input  logic [31:0]         sram_dout0,
    output logic                pwo_hold,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code,
    output logic [ADDR_W:0]     word_cnt,
    output logic [15:0]         checksum
);

    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

    ldr_state_e        state_q, state_d;
    logic              csb_q, csb_d, web_q, web_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       din_q, din_d;
    logic              gnt_q, gnt_d, rd_p1_q, rd_p1_d, rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              start_pend_q, start_pend_d;
    logic              byte_ready_q, byte_ready_d, busy_q, busy_d;
    logic              done_q, done_d, err_q, err_d, pwo_hold_q, pwo_hold_d;

    logic              pk_clear_c, pk_accept_c, word_full_c, rd_busy_c, in_load_c;
    logic [31:0]       word_q, word_next_c;
    logic [CNT_W-1:0]  wc_inc_c;

    assign pk_accept_c = host.byte_valid && byte_ready_q;
    assign rd_busy_c   = (gnt_q && web_q) || rd_p1_q;
    assign wc_inc_c    = word_cnt_q + CNT_W'(1);
    assign in_load_c   = state_q inside {ST_COLLECT, ST_WRITE, ST_VRD, ST_VWAIT,
                                         ST_VCMP, ST_SETTLE};

    hp35_ldr_packer u_packer (
        .clk         (osc_in),
        .rst         (ldr_rst),
        .clear_i     (pk_clear_c),
        .accept_i    (pk_accept_c),
        .byte_i      (host.byte_data),
        .word_o      (word_q),
        .word_next_c (word_next_c),
        .word_full_c (word_full_c),
        .checksum_o  (checksum)
    );

    // Next state, port-0 strobes and status, all registered from state_d.
    always_comb begin
        state_d      = state_q;
        csb_d        = 1'b1;
        web_d        = 1'b1;
        addr_d       = addr_q;
        din_d        = din_q;
        gnt_d        = 1'b0;
        rd_p1_d      = gnt_q && web_q;
        rvalid_d     = rd_p1_q;
        rdata_d      = rd_p1_q ? sram_dout0 : rdata_q;
        word_cnt_d   = word_cnt_q;
        err_code_d   = err_code_q;
        hold_d       = hold_q;
        start_pend_d = start_pend_q;
        pk_clear_c   = 1'b0;

        if (in_load_c && abort) begin
            state_d    = ST_ERROR;
            err_code_d = ERR_ABORT;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    // A start seen during an outstanding debug read is held until it retires.
                    if (start || start_pend_q) begin
                        if (rd_busy_c) begin
                            start_pend_d = 1'b1;
                        end else begin
                            start_pend_d = 1'b0;
                            state_d      = ST_COLLECT;
                            word_cnt_d   = '0;
                            err_code_d   = ERR_NONE;
                            pk_clear_c   = 1'b1;
                        end
                    end else if (host.dbg_req && !rd_busy_c) begin
                        gnt_d  = 1'b1;
                        csb_d  = 1'b0;
                        web_d  = host.dbg_web;
                        addr_d = host.dbg_addr;
                        din_d  = host.dbg_din;
                    end
                end
                ST_COLLECT: begin
                    if (word_full_c) begin
                        state_d = ST_WRITE;
                        csb_d   = 1'b0;
                        web_d   = 1'b0;
                        addr_d  = word_cnt_q[ADDR_W-1:0];
                        din_d   = word_next_c;
                    end
                end
                ST_WRITE: begin
                    state_d = ST_VRD;
                    csb_d   = 1'b0;
                end
                ST_VRD:   state_d = ST_VWAIT;
                ST_VWAIT: state_d = ST_VCMP;
                ST_VCMP: begin
                    if (sram_dout0 != word_q) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_VERIFY;
                    end else begin
                        word_cnt_d = wc_inc_c;
                        if (wc_inc_c == CNT_W'(WORDS)) begin
                            state_d = ST_SETTLE;
                            hold_d  = HOLD_W'(HOLD_CYCLES);
                        end else begin
                            state_d = ST_COLLECT;
                        end
                    end
                end
                ST_SETTLE: begin
                    hold_d = hold_q - HOLD_W'(1);
                    if (hold_q == HOLD_W'(1)) state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        byte_ready_d = (state_d == ST_COLLECT);
        busy_d       = state_d inside {ST_COLLECT, ST_WRITE, ST_VRD, ST_VWAIT,
                                       ST_VCMP, ST_SETTLE};
        done_d       = (state_d == ST_DONE);
        err_d        = (state_d == ST_ERROR);
        pwo_hold_d   = (state_d != ST_DONE);
    end

    always_ff @(posedge osc_in or posedge ldr_rst) begin
        if (ldr_rst) begin
            state_q      <= ST_IDLE;
            csb_q        <= 1'b1;
            web_q        <= 1'b1;
            addr_q       <= '0;
            din_q        <= '0;
            gnt_q        <= 1'b0;
            rd_p1_q      <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            word_cnt_q   <= '0;
            err_code_q   <= ERR_NONE;
            hold_q       <= '0;
            start_pend_q <= 1'b0;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            pwo_hold_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            csb_q        <= csb_d;
            web_q        <= web_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            gnt_q        <= gnt_d;
            rd_p1_q      <= rd_p1_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            word_cnt_q   <= word_cnt_d;
            err_code_q   <= err_code_d;
            hold_q       <= hold_d;
            start_pend_q <= start_pend_d;
            byte_ready_q <= byte_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            pwo_hold_q   <= pwo_hold_d;
        end
    end

    assign sram_csb0       = csb_q;
    assign sram_web0       = web_q;
    assign sram_wmask0     = 4'hF;
    assign sram_addr0      = addr_q;
    assign sram_din0       = din_q;
    assign host.byte_ready = byte_ready_q;
    assign host.dbg_gnt    = gnt_q;
    assign host.dbg_rdata  = rdata_q;
    assign host.dbg_rvalid = rvalid_q;
    assign pwo_hold        = pwo_hold_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign err_code        = err_code_q;
    assign word_cnt        = word_cnt_q;

endmodule

// File: tb/tb_hp35_rom_loader.sv
// Randomized self-checking bench for hp35_rom_loader with an ideal SRAM model.
module tb_hp35_rom_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned WORDS  = 4;
    localparam int unsigned HOLD   = 16;
    localparam int unsigned NBYTES = 4 * WORDS;
    localparam int          BUDGET = 400;

    logic              osc_in = 1'b0;
    logic              ldr_rst, start, abort;
    logic              sram_csb0, sram_web0;
    logic [3:0]        sram_wmask0;
    logic [ADDR_W-1:0] sram_addr0;
    logic [31:0]       sram_din0, sram_dout0;
    logic              pwo_hold, busy, done, err;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   word_cnt;
    logic [15:0]       checksum;

    logic [31:0] mem [256];
    logic [7:0]  stream [NBYTES];
    int          corrupt_at = -1;
    int          n_vec = 0;
    int          n_err = 0;

    hp35_rom_loader_if #(.ADDR_W(ADDR_W)) host_if ();

    hp35_rom_loader #(.ADDR_W(ADDR_W), .WORDS(WORDS), .HOLD_CYCLES(HOLD)) dut (
        .osc_in      (osc_in),
        .ldr_rst     (ldr_rst),
        .start       (start),
        .abort       (abort),
        .host        (host_if),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0),
        .pwo_hold    (pwo_hold),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .word_cnt    (word_cnt),
        .checksum    (checksum)
    );

    always #5 osc_in = ~osc_in;

    // Ideal single-port SRAM; read data appears after the strobe edge.
    always @(posedge osc_in) begin
        if (!sram_csb0) begin
            if (!sram_web0) mem[sram_addr0] <= sram_din0 & {{8{sram_wmask0[3]}}, {8{sram_wmask0[2]}},
                                                            {8{sram_wmask0[1]}}, {8{sram_wmask0[0]}}};
            else if (corrupt_at >= 0 && int'(sram_addr0) == corrupt_at)
                sram_dout0 <= mem[sram_addr0] ^ 32'h1;
            else
                sram_dout0 <= mem[sram_addr0];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge osc_in);
        #1;
    endtask

    function automatic logic [31:0] model_word(input int i);
        return {stream[4*i+3], stream[4*i+2], stream[4*i+1], stream[4*i]};
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NBYTES; i++) stream[i] = 8'($urandom);
    endtask

    task automatic run_load(input int gap_mode, input int abort_after, input int corrupt_wd,
                            input bit rst_at_vrd, input bit dbg_hold, input bit skip_start);
        int          acc = 0;
        int          t = 0;
        int          t_vrd = -1;
        int          t_pwo = -1;
        bit          fin = 0;
        bit          rst_hit = 0;
        logic [15:0] sum = '0;
        corrupt_at = corrupt_wd;
        if (!skip_start) begin
            start = 1'b1;
            step();
            start = 1'b0;
            check_eq("start_busy", busy, 1);
            check_eq("start_ready", host_if.byte_ready, 1);
            check_eq("start_cnt", word_cnt, 0);
            check_eq("start_sum", checksum, 0);
            check_eq("start_flags", {done, err, err_code}, 0);
            check_eq("start_pwo", pwo_hold, 1);
            if (dbg_hold) check_eq("start_prio_gnt", host_if.dbg_gnt, 0);
        end
        while (!fin && t < BUDGET) begin
            bit ab, v, rdy;
            ab = (abort_after >= 0) && (acc == abort_after);
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (t % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            v = v && !ab && (acc < NBYTES);
            host_if.byte_valid = v;
            host_if.byte_data  = v ? stream[acc % NBYTES] : 8'($urandom);
            abort = ab;
            rdy   = host_if.byte_ready;
            step();
            t++;
            host_if.byte_valid = 1'b0;
            abort = 1'b0;
            if (v && rdy) begin
                sum += 16'(stream[acc]);
                acc++;
            end
            if (ab) begin
                check_eq("abort_err", {err, err_code}, {1'b1, 2'd2});
                check_eq("abort_csb", sram_csb0, 1);
                check_eq("abort_busy_pwo", {busy, pwo_hold, host_if.byte_ready}, 3'b010);
                fin = 1;
            end
            if (pwo_hold == 1'b0 && t_pwo < 0) t_pwo = t;
            if (!sram_csb0 && sram_web0) begin
                t_vrd = t;
                if (rst_at_vrd) begin
                    ldr_rst = 1'b1;
                    #1;
                    check_eq("rst_sram", {sram_csb0, sram_web0, sram_wmask0}, 6'b11_1111);
                    check_eq("rst_addr_din", {24'(sram_addr0), sram_din0} == '0, 1);
                    check_eq("rst_flags", {pwo_hold, busy, done, err, err_code, host_if.byte_ready}, 7'b1000000);
                    check_eq("rst_cnt_sum", {word_cnt, checksum}, 0);
                    ldr_rst = 1'b0;
                    fin = 1;
                    rst_hit = 1;
                end
            end
            if (dbg_hold) check_eq("dbg_gnt_busy", host_if.dbg_gnt, 0);
            if (done || err) fin = 1;
        end
        check_eq("load_timeout", fin, 1);
        if (rst_hit) return;
        check_eq("checksum", checksum, sum);
        if (abort_after >= 0) begin
            check_eq("abort_cnt", word_cnt, abort_after / 4);
            check_eq("abort_acc", acc, abort_after);
        end else if (corrupt_wd >= 0) begin
            check_eq("vfy_err", {err, err_code, done}, {1'b1, 2'd1, 1'b0});
            check_eq("vfy_cnt", word_cnt, corrupt_wd);
            check_eq("vfy_pwo", {pwo_hold, host_if.byte_ready, busy}, 3'b100);
            check_eq("vfy_acc", acc, 4 * (corrupt_wd + 1));
            for (int i = 0; i < corrupt_wd; i++) check_eq("vfy_mem", mem[i], model_word(i));
        end else begin
            check_eq("done_flags", {done, err, busy, host_if.byte_ready}, 4'b1000);
            check_eq("done_cnt", word_cnt, WORDS);
            check_eq("done_pwo", pwo_hold, 0);
            check_eq("pwo_delay", t_pwo - (t_vrd + 2), HOLD + 1);
            for (int i = 0; i < int'(WORDS); i++) check_eq("img_word", mem[i], model_word(i));
        end
    endtask

    initial begin
        logic [31:0] img [4];
        int          gnts;
        img = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        ldr_rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        host_if.byte_valid = 1'b0;
        host_if.byte_data  = '0;
        host_if.dbg_req    = 1'b0;
        host_if.dbg_web    = 1'b1;
        host_if.dbg_addr   = '0;
        host_if.dbg_din    = '0;
        sram_dout0 = '0;
        step();
        step();
        check_eq("reset_sram", {sram_csb0, sram_web0, sram_wmask0}, 6'b11_1111);
        check_eq("reset_flags", {pwo_hold, busy, done, err, err_code, host_if.byte_ready}, 7'b1000000);
        check_eq("reset_dbg", {host_if.dbg_gnt, host_if.dbg_rvalid, host_if.dbg_rdata == 32'h0}, 3'b001);
        check_eq("reset_cnt_sum", {word_cnt, checksum}, 0);
        ldr_rst = 1'b0;
        step();
        check_eq("idle_pwo", pwo_hold, 1);

        // Directed image 0x00..0x0F with a debug write held pending throughout.
        for (int i = 0; i < int'(NBYTES); i++) stream[i] = 8'(i);
        host_if.dbg_req  = 1'b1;
        host_if.dbg_web  = 1'b0;
        host_if.dbg_addr = 8'h10;
        host_if.dbg_din  = 32'hDEADBEEF;
        run_load(0, -1, -1, 1'b0, 1'b1, 1'b0);
        check_eq("img_sum", checksum, 16'h0078);
        for (int i = 0; i < 4; i++) check_eq("img_const", mem[i], img[i]);
        step();
        check_eq("dbg_wr_gnt", host_if.dbg_gnt, 1);
        check_eq("dbg_wr_port", {sram_csb0, sram_web0, sram_addr0}, {2'b00, 8'h10});
        check_eq("dbg_wr_din", sram_din0, 32'hDEADBEEF);
        host_if.dbg_req = 1'b0;
        step();
        check_eq("dbg_wr_once", host_if.dbg_gnt, 0);
        check_eq("dbg_wr_mem", mem[8'h10], 32'hDEADBEEF);
        host_if.dbg_req = 1'b1;
        host_if.dbg_web = 1'b1;
        step();
        check_eq("dbg_rd_gnt", host_if.dbg_gnt, 1);
        host_if.dbg_req = 1'b0;
        step();
        check_eq("dbg_rd_early", host_if.dbg_rvalid, 0);
        step();
        check_eq("dbg_rd_valid", host_if.dbg_rvalid, 1);
        check_eq("dbg_rd_data", host_if.dbg_rdata, 32'hDEADBEEF);
        step();
        check_eq("dbg_rd_pulse", host_if.dbg_rvalid, 0);

        // Held requests: writes every cycle, reads every third cycle.
        host_if.dbg_req  = 1'b1;
        host_if.dbg_web  = 1'b0;
        host_if.dbg_addr = 8'($urandom_range(32, 255));
        host_if.dbg_din  = $urandom;
        gnts = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            gnts += int'(host_if.dbg_gnt);
        end
        check_eq("dbg_wr_b2b", gnts, 6);
        host_if.dbg_req = 1'b0;
        step();
        host_if.dbg_req  = 1'b1;
        host_if.dbg_web  = 1'b1;
        host_if.dbg_addr = 8'h10;
        gnts = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            gnts += int'(host_if.dbg_gnt);
        end
        check_eq("dbg_rd_rate", gnts, 2);
        host_if.dbg_req = 1'b0;
        repeat (3) step();

        // Start during an outstanding read waits for dbg_rvalid, then verify-fault load.
        fill_random();
        host_if.dbg_req = 1'b1;
        step();
        check_eq("pend_gnt", host_if.dbg_gnt, 1);
        host_if.dbg_req = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("pend_wait", busy, 0);
        step();
        check_eq("pend_rvalid", {host_if.dbg_rvalid, busy}, 2'b10);
        check_eq("pend_rdata", host_if.dbg_rdata, 32'hDEADBEEF);
        step();
        check_eq("pend_start", {busy, host_if.byte_ready, done}, 3'b110);
        run_load(2, -1, 2, 1'b0, 1'b0, 1'b1);

        // Abort after five bytes, then a clean reload with 1-0-1 byte gaps.
        fill_random();
        run_load(0, 5, -1, 1'b0, 1'b0, 1'b0);
        fill_random();
        run_load(1, -1, -1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset during the first verify read, then restart from word 0.
        fill_random();
        run_load(2, -1, -1, 1'b1, 1'b0, 1'b0);
        step();
        fill_random();
        run_load(2, -1, -1, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_load(2, -1, -1, 1'b0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hp35_rom_loader.md
Name: hp35_rom_loader

Overview:
- Boots the hp35 microcode store: accepts a host byte stream, packs it little-endian into 32-bit words and writes the words into the 256x32 SRAM write/read port 0. Each word is read back and verified.
- Keeps the calculator core in reset (pwo_hold) until the image is loaded and a settle delay has elapsed.
- Owns SRAM port 0 and arbitrates it against a single-word debug requester from the Caravel LA.

Parameters:
- ADDR_W, 8, SRAM word address width
- WORDS, 256, words per image (1..2^ADDR_W)
- HOLD_CYCLES, 16, osc_in cycles between load complete and pwo_hold release (>=1)

Ports:
- osc_in  in  1  clock
- ldr_rst  in  1  asynchronous active-high reset
- start  in  1  pulse; begin load at address 0
- abort  in  1  pulse; abandon load
- byte_valid  in  1  host byte strobe
- byte_data  in  8  host byte
- byte_ready  out  1  loader accepts byte this cycle
- dbg_req  in  1  debug single-word access request
- dbg_web  in  1  0=write, 1=read
- dbg_addr  in  ADDR_W  debug address
- dbg_din  in  32  debug write data
- dbg_gnt  out  1  one-cycle grant pulse; access issued this cycle
- dbg_rdata  out  32  debug read data
- dbg_rvalid  out  1  one-cycle pulse, dbg_rdata valid
- sram_csb0  out  1  port-0 chip select, active low
- sram_web0  out  1  port-0 write enable, active low
- sram_wmask0  out  4  write mask
- sram_addr0  out  ADDR_W  port-0 address
- sram_din0  out  32  port-0 write data
- sram_dout0  in  32  port-0 read data
- pwo_hold  out  1  1 = hold calculator core in reset
- busy  out  1  load in progress
- done  out  1  image loaded and verified (sticky until start)
- err  out  1  sticky error flag
- err_code  out  2  0 none, 1 verify mismatch, 2 aborted
- word_cnt  out  ADDR_W+1  words written and verified
- checksum  out  16  sum of accepted bytes, mod 2^16

Behaviour:
- All outputs are registered.
- Reset values:
  - sram_csb0=1, sram_web0=1, sram_wmask0=4'hF, sram_addr0=0, sram_din0=0
  - pwo_hold=1
  - byte_ready, busy, done, err, dbg_gnt, dbg_rvalid = 0
  - err_code=0, word_cnt=0, checksum=0, dbg_rdata=0
- Reset mid-operation aborts immediately to IDLE with these values. SRAM contents are undefined.
- States: IDLE, COLLECT, WRITE, VRD, VWAIT, VCMP, SETTLE, DONE, ERROR.
- IDLE/DONE/ERROR:
  - start -> COLLECT: clears done, err, err_code, word_cnt, checksum and byte index; sets pwo_hold=1, busy=1.
  - start has priority over dbg_req in the same cycle.
  - start in any other state is ignored.
- COLLECT:
  - byte_ready=1. Each cycle with byte_valid&&byte_ready, the byte goes to lane idx (bits 8*idx+7:8*idx) and checksum += byte.
  - Accepting the 4th byte -> WRITE.
- WRITE (1 cycle): csb0=0, web0=0, addr=word_cnt, din=packed word. -> VRD.
- VRD (1 cycle): csb0=0, web0=1, same addr. -> VWAIT.
- VWAIT (1 cycle): csb0=1. -> VCMP.
- VCMP: sram_dout0 is sampled and compared to the shadow word.
  - Mismatch -> ERROR with err_code=1.
  - Match: word_cnt++. If word_cnt becomes WORDS -> SETTLE, else -> COLLECT.
- Throughput: minimum 4 cycles per word in COLLECT, then 4 cycles write/verify. byte_ready=0 outside COLLECT.
- SETTLE:
  - A counter loads HOLD_CYCLES and decrements each cycle. At 0 -> DONE with busy=0, done=1, pwo_hold=0.
  - pwo_hold falls exactly HOLD_CYCLES+1 cycles after the final VCMP.
- abort in COLLECT..SETTLE -> ERROR with err_code=2.
  - Any SRAM strobe in flight completes its single cycle; the next cycle drives csb0=1.
  - abort in IDLE/DONE/ERROR is ignored.
- ERROR: err=1, busy=0, pwo_hold=1.
- Debug arbitration:
  - dbg_req is served only in IDLE, DONE or ERROR, and only when start is not asserted. The loader always wins.
  - A grant drives one port cycle: csb0=0, web0=dbg_web, addr=dbg_addr, din=dbg_din, with dbg_gnt=1 in that cycle.
  - For reads, dbg_rdata is captured from sram_dout0 two cycles later, with dbg_rvalid pulsed in that cycle.
  - No new grant is issued while a read is outstanding. A start arriving meanwhile waits for dbg_rvalid.
  - dbg_req held high yields back-to-back write grants. Reads are granted every 3rd cycle.
- word_cnt width ADDR_W+1 so WORDS=256 is representable. Address never wraps.
- Checksum wraps modulo 2^16.

Decomposition:
- Package hp35_ldr_pkg: state enum, err_code constants (ERR_NONE=0, ERR_VERIFY=1, ERR_ABORT=2), BYTES_PER_WORD=4.
- Sub-module hp35_ldr_packer: byte lane index, 32-bit shadow word, checksum accumulator. Ports: clear, accept, byte in; word and word_full out.
- FSM and arbiter stay in the top module.

Test Plan:
- WORDS=4, HOLD_CYCLES=16, stream 16 bytes 0x00..0x0F with byte_valid held, SRAM model ideal:
  - SRAM holds 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C at addresses 0..3.
  - checksum=0x0078, word_cnt=4, done=1.
  - pwo_hold falls 17 cycles after the last VCMP.
- Model corrupts bit 0 of the readback at address 2 -> err=1, err_code=1, word_cnt=2, pwo_hold stays 1, byte_ready=0.
- abort after 5 bytes -> ERROR with err_code=2 on the next cycle, csb0=1. A following start reloads cleanly from address 0.
- dbg_req write 0xDEADBEEF @0x10 while busy -> no dbg_gnt until DONE. After DONE: grant in 1 cycle, then a read returns 0xDEADBEEF with dbg_rvalid 2 cycles after its grant.
- ldr_rst pulsed during VRD -> all outputs return to reset values asynchronously (pwo_hold=1, csb0=1). The next start restarts at word 0.
- Byte gaps: byte_valid toggled 1-0-1 over 8 bytes -> packing is unaffected and the two written words match the data.
